fetch_unit: RTL

- Instruction-fetch front end of the 5-stage core.
- Responds to the pipeline control unit's redirect and stall signals, issues in-order requests to instruction memory over a valid/ready interface, and buffers returned instructions.
- Delivers {pc, instr} to the ID pipeline register.
- Discards responses made stale by a redirect (taken branch or jump).

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_buffer.sv | 74 +++++++
 rtl/fetch_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_unit_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetch entries with flush; used both as the
// instruction buffer towards ID and as the in-flight request pc queue.
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [CW-1:0] count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Pointer increment that wraps at DEPTH, so non power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state: flush wins; otherwise push and pop may happen together.
    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_q] = push_data_i;
                wr_d        = ptr_inc(wr_q);
            end
            if (pop_i) begin
                rd_d = ptr_inc(rd_q);
            end
            cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // State registers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: in-order imem requests with credit flow
// control, response buffering towards ID, and redirect-driven discard of
// stale responses. Optional macro FETCH_BYPASS_EN lets a response go straight
// to ID when the buffer is empty.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FB_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o
);

    // Room for FB_DEPTH in flight plus one pending unaccepted request.
    localparam int CW = $clog2(FB_DEPTH + 2);
    localparam int BW = $clog2(FB_DEPTH + 1);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] kill_q, kill_d;
    logic          hold_q, hold_d;
    logic [31:0]   hold_addr_q, hold_addr_d;

    logic          buf_push, buf_pop, buf_full, buf_empty;
    logic [BW-1:0] buf_cnt;
    fetch_entry_t  buf_head, resp_entry;

    logic          side_push, side_pop, side_full, side_empty;
    logic [BW-1:0] side_cnt;
    fetch_entry_t  side_head, side_data;

    logic          credit, req_fire, resp_live, byp;

    // Request side: a held request keeps its address even across a redirect.
    always_comb begin
        credit           = (int'(out_q) + int'(buf_cnt)) < FB_DEPTH;
        imem_req_valid_o = reset_ni &&
                           (hold_q || (state_q == FETCH_RUN && !stall_i && credit));
        imem_req_addr_o  = hold_q ? hold_addr_q : pc_q;
        req_fire         = imem_req_valid_o && imem_req_ready_i;
        resp_live        = imem_resp_valid_i && (state_q == FETCH_RUN) && !redirect_i;
        side_push        = req_fire && (state_q == FETCH_RUN) && !redirect_i;
        side_pop         = resp_live;
        side_data        = '{pc: imem_req_addr_o, instr: 32'h0};
        resp_entry       = '{pc: side_head.pc, instr: imem_resp_data_i};
    end

    // ID side: registered head, optionally bypassed by a same-cycle response.
    always_comb begin
`ifdef FETCH_BYPASS_EN
        byp        = reset_ni && buf_empty && resp_live;
        id_valid_o = !buf_empty || byp;
        id_pc_o    = byp ? resp_entry.pc    : buf_head.pc;
        id_instr_o = byp ? resp_entry.instr : buf_head.instr;
        buf_push   = resp_live && !(byp && id_ready_i);
`else
        byp        = 1'b0;
        id_valid_o = !buf_empty;
        id_pc_o    = buf_head.pc;
        id_instr_o = buf_head.instr;
        buf_push   = resp_live;
`endif
        buf_pop    = !buf_empty && id_ready_i;
    end

    // Control: pc advance, in-flight count, kill count and RUN/FLUSH state.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        hold_d      = imem_req_valid_o && !imem_req_ready_i;
        hold_addr_d = imem_req_addr_o;
        out_d       = out_q + CW'(req_fire) - CW'(imem_resp_valid_i);
        // Only fresh requests advance the pc; a stale held one in FLUSH must not.
        if (req_fire && state_q == FETCH_RUN) begin
            pc_d = pc_q + 32'(INSTR_BYTES);
        end
        if (redirect_i) begin
            pc_d    = {redirect_pc_i[31:2], 2'b00};
            kill_d  = out_d + CW'(hold_d);
            state_d = (kill_d != '0) ? FETCH_FLUSH : FETCH_RUN;
        end else if (state_q == FETCH_FLUSH) begin
            kill_d = kill_q - CW'(imem_resp_valid_i);
            if (kill_d == '0 && !hold_d) state_d = FETCH_RUN;
        end
    end

    // Control registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= FETCH_RUN;
            pc_q        <= RESET_PC;
            out_q       <= '0;
            kill_q      <= '0;
            hold_q      <= 1'b0;
            hold_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_q       <= out_d;
            kill_q      <= kill_d;
            hold_q      <= hold_d;
            hold_addr_q <= hold_addr_d;
        end
    end

    fetch_buffer #(.DEPTH(FB_DEPTH)) u_ibuf (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .push_i      (buf_push),
        .push_data_i (resp_entry),
        .pop_i       (buf_pop),
        .flush_i     (redirect_i),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (buf_cnt),
        .head_o      (buf_head)
    );

    // Carries the pc of each fresh in-flight request to its response.
    fetch_buffer #(.DEPTH(FB_DEPTH)) u_pcq (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .push_i      (side_push),
        .push_data_i (side_data),
        .pop_i       (side_pop),
        .flush_i     (redirect_i),
        .full_o      (side_full),
        .empty_o     (side_empty),
        .count_o     (side_cnt),
        .head_o      (side_head)
    );

    // Credit flow makes overflow impossible; in RUN every in-flight request has a pc.
    a_ibuf_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_ni)
        buf_push |-> (!buf_full || buf_pop));
    a_pcq_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_ni)
        side_push |-> (!side_full || side_pop));
    a_pcq_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_ni)
        side_pop |-> (!side_empty && side_head.instr == 32'h0));
    a_pcq_tracks_inflight: assert property (@(posedge clk_i) disable iff (!reset_ni)
        (state_q == FETCH_RUN) |-> (int'(side_cnt) == int'(out_q)));

endmodule
